// File: rtl/booth_radix4_mul.sv
// rtl/booth_radix4_mul.sv - multi-cycle radix-4 Booth multiplier, signed/unsigned, valid/ready on both sides
module booth_radix4_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     mul1,
  input  logic [WIDTH-1:0]     mul2,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int EXT  = (WIDTH % 2 == 0) ? WIDTH + 2 : WIDTH + 1;
  localparam int ITER = EXT / 2;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [EXT-1:0] r_m;
  logic [EXT-1:0] r_mplr;
  logic [EXT+1:0] r_a;
  logic [EXT-1:0] r_q;
  logic           r_qprev;
  logic           r_in_ready;
  logic           r_out_valid;

  logic [EXT-1:0] w_mul1_ext;
  logic [EXT-1:0] w_mul2_ext;
  logic           w_first;
  logic [EXT+1:0] w_a_cur;
  logic [EXT-1:0] w_q_cur;
  logic           w_qprev_cur;
  logic [2:0]     w_triple;
  logic [EXT+1:0] w_m_ext;
  logic [EXT+1:0] w_addend;
  logic [EXT+1:0] w_sum;
  logic [EXT+1:0] w_a_next;
  logic [EXT-1:0] w_q_next;

  assign w_mul1_ext = signed_mode ? {{(EXT-WIDTH){mul1[WIDTH-1]}}, mul1}
                                  : {{(EXT-WIDTH){1'b0}}, mul1};
  assign w_mul2_ext = signed_mode ? {{(EXT-WIDTH){mul2[WIDTH-1]}}, mul2}
                                  : {{(EXT-WIDTH){1'b0}}, mul2};

  // The accumulator is left untouched at capture so the previous product stays
  // visible until the first step; that step seeds A=0, Q=multiplier, q_prev=0.
  assign w_first     = (r_cnt == CW'(ITER));
  assign w_a_cur     = w_first ? '0 : r_a;
  assign w_q_cur     = w_first ? r_mplr : r_q;
  assign w_qprev_cur = w_first ? 1'b0 : r_qprev;
  assign w_triple    = {w_q_cur[1:0], w_qprev_cur};
  assign w_m_ext     = {{2{r_m[EXT-1]}}, r_m};

  always_comb begin
    w_addend = '0;
    case (w_triple)
      3'b001, 3'b010: w_addend = w_m_ext;
      3'b011:         w_addend = {w_m_ext[EXT:0], 1'b0};
      3'b100:         w_addend = -{w_m_ext[EXT:0], 1'b0};
      3'b101, 3'b110: w_addend = -w_m_ext;
      default:        w_addend = '0;
    endcase
  end

  assign w_sum    = w_a_cur + w_addend;
  assign w_a_next = {{2{w_sum[EXT+1]}}, w_sum[EXT+1:2]};
  assign w_q_next = {w_sum[1:0], w_q_cur[EXT-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_m         <= '0;
      r_mplr      <= '0;
      r_a         <= '0;
      r_q         <= '0;
      r_qprev     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_m        <= w_mul1_ext;
            r_mplr     <= w_mul2_ext;
            r_cnt      <= CW'(ITER);
            r_state    <= S_CALC;
            r_in_ready <= 1'b0;
          end
        end
        S_CALC: begin
          r_a     <= w_a_next;
          r_q     <= w_q_next;
          r_qprev <= w_q_cur[1];
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = {r_a[2*WIDTH-EXT-1:0], r_q};

endmodule

// File: doc/booth_radix4_mul.md
# booth_radix4_mul

Parametrised, multi-cycle radix-4 (modified) Booth multiplier with valid/ready handshakes on both sides and a per-operation signed/unsigned mode. It retires two multiplier bits per cycle and produces the exact full-width product. It replaces the free-running radix-2 multiplier as the shared multiply engine behind the datapath's arithmetic units. Operands are captured once per transaction. The result is held until the consumer takes it.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 4..32, odd values allowed.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand transaction offered.
- `in_ready` output 1: block can accept an operand transaction.
- `mul1` input `WIDTH`: multiplicand.
- `mul2` input `WIDTH`: multiplier.
- `signed_mode` input 1: 1 means operands and product are two's complement; 0 means unsigned.
- `out_valid` output 1: `product` is valid.
- `out_ready` input 1: consumer accepts `product`.
- `product` output `2*WIDTH`: exact product of the captured operands.

## Operation
- **Internal widths**
  - `EXT` = `WIDTH`+2 if `WIDTH` is even, else `WIDTH`+1 (always even, at least `WIDTH`+1).
  - `ITER` = `EXT`/2. For `WIDTH`=8, `ITER`=5; for `WIDTH`=7, `ITER`=4.
- **Capture**
  - An operand transaction is accepted on an edge with `in_valid`=1 and `in_ready`=1.
  - On that edge, `mul1`, `mul2` and `signed_mode` are latched.
  - Both operands are extended to `EXT` bits: sign-extended if `signed_mode`=1, zero-extended if 0.
  - Input changes after acceptance have no effect.
- **Recoding**
  - Each step examines the triple {Q[1], Q[0], q_prev}; q_prev is 0 at start.
  - Triple to action on the partial accumulator:
    - 000, 111: +0
    - 001, 010: +M
    - 011: +2M
    - 100: -2M
    - 101, 110: -M
  - The accumulator is `EXT`+2 bits, sign-extended; ±2M is formed by a left shift, -M by two's complement.
  - After the add, {A, Q, q_prev} shifts right arithmetically by 2.
- **Result**
  - After `ITER` steps, `product` is the low `2*WIDTH` bits of {A, Q}.
  - The result is exact for all operand pairs in both modes, with no overflow.
- **States**
  - IDLE: `in_ready`=1, `out_valid`=0. An accepted transaction moves to CALC with step counter = `ITER`.
  - CALC: `in_ready`=0. One recode/add/shift per edge; the counter decrements. The edge that executes the last step moves to DONE.
  - DONE: `out_valid`=1, `in_ready`=0, `product` stable. An edge with `out_ready`=1 moves to IDLE; otherwise the block stays in DONE indefinitely.
- **Idle/ignore rules**
  - `in_valid` is ignored in CALC and DONE.
  - `out_ready` is ignored outside DONE.
  - There is no overlap of transactions.

## Timing
- **Reset**
  - Asserting `rst_n` low, at any time including mid-CALC or in DONE, immediately forces state to IDLE.
  - Reset values: `in_ready`=1, `out_valid`=0, `product`=0, step counter=0.
  - Any in-flight operation is discarded; no stale result appears after reset.
- **Latency and throughput**
  - Accept edge at cycle 0; `out_valid` rises after edge `ITER` (5 cycles for `WIDTH`=8).
  - Minimum issue interval is `ITER`+2 cycles: accept, `ITER` CALC edges, and one DONE edge with `out_ready`=1.
- **Output timing**
  - `in_ready` and `out_valid` are registered, decoded from state only, with no combinational path from `in_valid` or `out_ready`.
  - `product` is driven from the accumulator registers. It may change during CALC and must be sampled only when `out_valid`=1.
  - On leaving DONE, `product` holds its value until the next CALC step modifies it.
- **Simultaneous events**
  - If `in_valid`=1 in the same cycle DONE is consumed, it is not accepted; `in_ready` rises on the following cycle.

## Test plan
- **Signed corner, `WIDTH`=8:** `signed_mode`=1, `mul1`=0x80 (-128), `mul2`=0x80 → `product`=0x4000; `out_valid` rises exactly 5 cycles after the accept edge.
- **Unsigned maximum, `WIDTH`=8:** `signed_mode`=0, `mul1`=0xFF, `mul2`=0xFF → `product`=0xFE01. Same operands with `signed_mode`=1 (-1 × -1) → `product`=0x0001.
- **Mixed signs and zero, `WIDTH`=8:** `signed_mode`=1, `mul1`=0xFD (-3), `mul2`=0x05 → `product`=0xFFF1. Then `mul1`=0x00, `mul2`=0x7F → `product`=0x0000.
- **Backpressure and input isolation:**
  - Hold `out_ready`=0 for 10 cycles after `out_valid` rises, with `in_valid`=1 and operands toggling every cycle.
  - Required: `product` stays stable, `in_ready`=0, and no new capture occurs.
  - Then pulse `out_ready`=1 → IDLE on the next edge, `in_ready`=1.
- **Reset mid-operation:**
  - Assert `rst_n`=0 two cycles into CALC, asynchronous to `clk`.
  - Required: `in_ready`=1, `out_valid`=0 and `product`=0 immediately, with no `out_valid` pulse after release.
  - Then issue `mul1`=0x07, `mul2`=0x06 unsigned → `product`=0x002A.
- **Exhaustive check:** all 256 operand pairs at `WIDTH`=4 and all 16384 pairs at `WIDTH`=7, both modes, back-to-back at minimum issue interval; every result is compared against a reference model.
